// File: rtl/shift_seq_pkg.sv
// Shared types and seed helpers for the LED chaser sequencer.
// Seed helpers are built at a fixed maximum width; callers keep the low WIDTH bits.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        MODE_RIGHT  = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned SEED_MAX_W = 64;

    function automatic logic [SEED_MAX_W-1:0] seed_msb(input int unsigned width);
        return {{(SEED_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

    function automatic logic [SEED_MAX_W-1:0] seed_lsb(input int unsigned width);
        return (width == 0) ? '0 : {{(SEED_MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_tick_gen.sv
// Step-rate prescaler: one tick every div_q enabled cycles.
// A loaded period of zero is clamped to one so the chaser never stalls.
module tick_gen #(
    parameter int unsigned      CNT_W       = 24,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 24'd13_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] counter_q, counter_d;

    assign tick = en && (counter_q == (div_q - ONE));

    always_comb begin
        div_d     = div_q;
        counter_d = counter_q;
        if (load) begin
            div_d     = (div == '0) ? ONE : div;
            counter_d = '0;
        end else if (clr) begin
            counter_d = '0;
        end else if (en) begin
            counter_d = tick ? '0 : counter_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= DEFAULT_DIV;
            counter_q <= '0;
        end else begin
            div_q     <= div_d;
            counter_q <= counter_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// LED chaser sequencer: IDLE/RUN control around a one-hot pattern register,
// stepping right/left/bounce/hold on each prescaler tick.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      CNT_W       = 24,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 24'd13_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] div,
    input  logic             div_load,
    output logic [WIDTH-1:0] out_bits,
    output logic             busy,
    output logic             done,
    output logic             step
);

    localparam logic [SEED_MAX_W-1:0] MSB_FULL = seed_msb(WIDTH);
    localparam logic [SEED_MAX_W-1:0] LSB_FULL = seed_lsb(WIDTH);
    localparam logic [WIDTH-1:0]      MSB      = MSB_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]      LSB      = LSB_FULL[WIDTH-1:0];
    localparam logic                  DIR_RIGHT = 1'b0;
    localparam logic                  DIR_LEFT  = 1'b1;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic             oneshot_q, oneshot_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             step_q, step_d;
    logic             tick;
    logic             start_ok;
    logic             complete;

    assign start_ok = (state_q == ST_IDLE) && start && !stop;

    tick_gen #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  ((state_q == ST_RUN) && !pause),
        .clr (start_ok),
        .load(div_load),
        .div (div),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_RIGHT;
            oneshot_q <= 1'b0;
            dir_q     <= DIR_RIGHT;
            out_q     <= MSB;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            oneshot_q <= oneshot_d;
            dir_q     <= dir_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (stop || (tick && complete)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stop outranks a coincident tick: no pattern update and no step pulse.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        oneshot_d = oneshot_q;
        step_d    = 1'b0;
        complete  = 1'b0;
        if (start_ok) begin
            mode_d    = mode_e'(mode);
            oneshot_d = oneshot;
            case (mode_e'(mode))
                MODE_RIGHT:  out_d = MSB;
                MODE_LEFT:   out_d = LSB;
                MODE_BOUNCE: begin
                    out_d = MSB;
                    dir_d = DIR_RIGHT;
                end
                default:     out_d = out_q;
            endcase
        end else if ((state_q == ST_RUN) && tick && !stop) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_RIGHT: begin
                    if (out_q == LSB) begin
                        if (oneshot_q) complete = 1'b1;
                        else           out_d    = MSB;
                    end else begin
                        out_d = out_q >> 1;
                    end
                end
                MODE_LEFT: begin
                    if (out_q == MSB) begin
                        if (oneshot_q) complete = 1'b1;
                        else           out_d    = LSB;
                    end else begin
                        out_d = out_q << 1;
                    end
                end
                MODE_BOUNCE: begin
                    if (dir_q == DIR_RIGHT) begin
                        if (out_q == LSB) begin
                            dir_d = DIR_LEFT;
                            out_d = out_q << 1;
                        end else begin
                            out_d = out_q >> 1;
                        end
                    end else if (out_q == MSB) begin
                        if (oneshot_q) begin
                            complete = 1'b1;
                        end else begin
                            dir_d = DIR_RIGHT;
                            out_d = out_q >> 1;
                        end
                    end else begin
                        out_d = out_q << 1;
                    end
                end
                default: complete = oneshot_q;
            endcase
        end
        done_d = complete;
        busy_d = (state_d == ST_RUN);
    end

    assign out_bits = out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step     = step_q;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the 8-bit one-hot LED chaser datapath. Holds the pattern register and a programmable step-rate prescaler, and runs the pattern in one of four modes (right, left, bounce, hold), either continuously or one-shot. Sits between board-level controls (buttons/UART command decoder) and the LED pins. Provides start/stop/pause control plus busy/done/step status.

Parameters:
WIDTH, 8, pattern width in bits (one-hot).
CNT_W, 24, prescaler counter width.
DEFAULT_DIV, 24'd13_500_000, step period in clk cycles after reset (0.5 s at 27 MHz).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; begins a run from IDLE.
stop  in  1  single-cycle pulse; aborts a run and returns to IDLE.
pause  in  1  level; while high in RUN, the prescaler and pattern freeze.
mode  in  2  0 = right, 1 = left, 2 = bounce, 3 = hold; sampled only on an accepted start.
oneshot  in  1  1 = finish after one pass; sampled only on an accepted start.
div  in  CNT_W  new step period in cycles.
div_load  in  1  pulse; captures div.
out_bits  out  WIDTH  pattern to LEDs.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse on one-shot completion.
step  out  1  one-cycle pulse, registered on the same edge that out_bits updates.

Behaviour:
- Reset values: out_bits = MSB-only (8'h80); state IDLE; busy 0, done 0, step 0; div_reg = DEFAULT_DIV; counter 0; dir = right.
- All outputs are registered.
- div_load: div_reg <= (div == 0) ? 1 : div on the next edge; counter cleared to 0. Permitted in any state.
- Prescaler: advances only in RUN with pause = 0. tick = (counter == div_reg - 1); on tick, counter wraps to 0. Step period = div_reg cycles.
- States are IDLE and RUN.
- IDLE: start with stop = 0 -> RUN on the next edge.
  - Latch mode and oneshot; clear counter.
  - Seed out_bits: right -> MSB; left -> LSB; bounce -> MSB with dir = right; hold -> unchanged.
  - If start and stop arrive in the same cycle, stop wins and the block stays in IDLE.
- RUN, on tick (pause = 0, stop = 0), step = 1 and:
  - right: if out == LSB -> oneshot ? complete : reload MSB; else shift right by 1.
  - left: mirror of right (LSB to MSB, reload LSB).
  - bounce: shift in dir. At LSB with dir right: flip dir to left and shift left (no dwell). At MSB with dir left: oneshot ? complete : flip dir and shift right.
  - hold: out_bits unchanged; oneshot ? complete : continue.
  - Complete: out_bits unchanged, step = 1, done = 1 for that cycle, -> IDLE.
- stop in RUN: -> IDLE on the next edge; out_bits retained; stop has priority over a coincident tick (no update, no step).
- start in RUN is ignored. mode/oneshot changes during RUN have no effect.
- Latency: start sampled at edge k -> busy = 1 after edge k; first step after edge k + div_reg.
- rst mid-run: immediate return to reset values, including div_reg.

Decomposition:
- Package shift_seq_pkg:
  - typedef enum logic [1:0] mode_e {MODE_RIGHT, MODE_LEFT, MODE_BOUNCE, MODE_HOLD}.
  - typedef enum logic state_e {ST_IDLE, ST_RUN}.
  - Functions seed_msb() and seed_lsb() parameterised by WIDTH.
- Sub-module tick_gen:
  - Prescaler with inputs en, clr, load/div; output tick.
  - Also implements the zero-to-one clamp on div.

Test Plan:
1. Pulse rst mid-run with out = 8'h10 -> out_bits = 8'h80, busy = 0, done = 0; after start, first step comes DEFAULT_DIV cycles later.
2. Load div = 3, mode right, oneshot = 0, start -> step every 3 cycles; out = 80, 40, 20, 10, 08, 04, 02, 01, 80 (wrap).
3. div = 2, mode left, oneshot = 1 -> 01 … 80 after 7 steps; 8th tick gives done + step, out stays 80, busy = 0 the next cycle.
4. div = 1, mode bounce, oneshot = 1 -> 80 → 01 → 80 over 14 shifts; done on the 15th tick with out = 80.
5. stop coincident with tick at out = 08 -> no step, out stays 08, IDLE. Then pause held 10 cycles in RUN -> no steps and counter frozen; release -> resumes.
6. div_load with div = 0, mode right continuous -> step every cycle. Also: start and stop in the same cycle in IDLE -> busy stays 0.
